// File: rtl/skid_register.sv
// skid_register: two-entry ready/valid pipeline register (main + skid).
// i_ready, o_valid, o_data and count are decoded from flops only, so no combinational path crosses the block.
`default_nettype none

module skid_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] i_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] o_data,
  output logic [1:0]   count
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   main_q;
  logic [N-1:0]   skid_q;
  logic           in_fire;
  logic           out_fire;
  logic           load_main_in;
  logic           load_main_skid;
  logic           load_skid;

  assign i_ready = (state != FULL);
  assign o_valid = (state != EMPTY);
  assign o_data  = main_q;
  assign count   = state;

  assign in_fire  = i_valid & i_ready;
  assign out_fire = o_valid & o_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_next     = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Data registers only load on a qualified handshake, so X on i_data while idle never enters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= i_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= i_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_skid_register.sv
// tb_skid_register: scoreboard bench for skid_register; words pushed on input fire, popped and compared on output fire.
`default_nettype none

module tb_skid_register;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] i_data;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] o_data;
  logic [1:0]   count;

  int           n_checks;
  int           n_fail;
  int           out_count;
  logic [N-1:0] sb_q[$];
  logic         hold;
  logic [N-1:0] held_data;

  skid_register #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    o_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!o_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", {31'd0, done}, 32'd1);
    tick();
    o_ready = 1'b0;
  endtask

  // Monitor: model occupancy, FIFO data and hold stability, sampled on the falling edge.
  initial begin
    hold = 1'b0;
    held_data = '0;
    out_count = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb_q.delete();
        hold = 1'b0;
      end else begin
        check("mon_count", {30'd0, count}, sb_q.size());
        check("mon_o_valid", {31'd0, o_valid}, {31'd0, sb_q.size() != 0});
        check("mon_i_ready", {31'd0, i_ready}, {31'd0, sb_q.size() != 2});
        if (hold) check("mon_stable", {24'd0, o_data}, {24'd0, held_data});
        if (flush) begin
          sb_q.delete();
          hold = 1'b0;
        end else begin
          if (o_valid && o_ready) begin
            check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) check("mon_data", {24'd0, o_data}, {24'd0, sb_q.pop_front()});
            out_count++;
          end
          if (i_valid && i_ready) sb_q.push_back(i_data);
          hold = o_valid && !o_ready;
          held_data = o_data;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       got;
    int         base;
    logic [7:0] seq;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    i_valid  = 1'b0;
    o_ready  = 1'b0;
    i_data   = '0;
    #2;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_i_ready", {31'd0, i_ready}, 32'd1);
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_o_data", {24'd0, o_data}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Single word in, then out.
    i_valid = 1'b1;
    i_data  = 8'hA5;
    tick();
    i_valid = 1'b0;
    check("single_o_valid", {31'd0, o_valid}, 32'd1);
    check("single_o_data", {24'd0, o_data}, 32'hA5);
    check("single_count", {30'd0, count}, 32'd1);
    check("single_i_ready", {31'd0, i_ready}, 32'd1);
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    check("single_empty_valid", {31'd0, o_valid}, 32'd0);
    check("single_empty_count", {30'd0, count}, 32'd0);

    // Backpressure fill: third word must wait.
    base    = out_count;
    i_valid = 1'b1;
    i_data  = 8'h01;
    tick();
    i_data  = 8'h02;
    tick();
    i_data  = 8'h03;
    check("bp_count", {30'd0, count}, 32'd2);
    check("bp_i_ready", {31'd0, i_ready}, 32'd0);
    check("bp_o_data", {24'd0, o_data}, 32'h01);
    repeat (3) tick();
    check("bp_hold_count", {30'd0, count}, 32'd2);
    check("bp_hold_data", {24'd0, o_data}, 32'h01);
    o_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_ready) begin
        got = 1'b1;
        break;
      end
    end
    tick();
    i_valid = 1'b0;
    check("bp_third_accepted", {31'd0, got}, 32'd1);
    drain();
    check("bp_out_words", out_count - base, 32'd3);

    // Streaming at full rate.
    base    = out_count;
    o_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_valid = 1'b1;
      i_data  = 8'(i);
      @(negedge clk);
      check("stream_i_ready", {31'd0, i_ready}, 32'd1);
      if (i > 0) check("stream_count", {30'd0, count}, 32'd1);
      tick();
    end
    i_valid = 1'b0;
    drain();
    check("stream_out_words", out_count - base, 32'd16);

    // Asynchronous reset while FULL.
    i_valid = 1'b1;
    i_data  = 8'h11;
    tick();
    i_data  = 8'h22;
    tick();
    i_valid = 1'b0;
    check("rstfull_count_pre", {30'd0, count}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_o_valid", {31'd0, o_valid}, 32'd0);
    check("rstmid_i_ready", {31'd0, i_ready}, 32'd1);
    check("rstmid_count", {30'd0, count}, 32'd0);
    check("rstmid_o_data", {24'd0, o_data}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rstpost_count", {30'd0, count}, 32'd0);
    check("rstpost_o_valid", {31'd0, o_valid}, 32'd0);

    // Flush while FULL, with both handshakes offered.
    i_valid = 1'b1;
    i_data  = 8'h55;
    tick();
    i_data  = 8'h66;
    tick();
    check("flush_pre_count", {30'd0, count}, 32'd2);
    base    = out_count;
    i_data  = 8'h77;
    o_ready = 1'b1;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    check("flush_count", {30'd0, count}, 32'd0);
    check("flush_o_valid", {31'd0, o_valid}, 32'd0);
    check("flush_i_ready", {31'd0, i_ready}, 32'd1);
    check("flush_no_pop", out_count - base, 32'd0);
    repeat (2) tick();
    check("flush_stays_empty", {30'd0, count}, 32'd0);

    // Random stalls with an incrementing data pattern.
    seq = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = i_valid ? seq : 'x;
      o_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i_valid && i_ready) seq++;
      tick();
    end
    i_valid = 1'b0;
    drain();
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/skid_register.md
Name: skid_register

Overview:
- Ready/valid pipeline register: the handshaked counterpart to the plain enable register.
- The write side pushes words in; the read side pops them when it is ready.
- Placed between pipeline stages. It breaks the combinational backpressure path, so i_ready is a pure flop output with no path from o_ready.
- Holds up to two words: a main register and a skid register. Full throughput (one word per cycle) is sustained when both sides are continuously active.

Parameters:
- N, 8, data word width in bits (legal: N >= 1).

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion synchronous to clk.
- flush  input  1  synchronous discard of all held words; active-high.
- i_valid  input  1  upstream presents i_data this cycle.
- i_ready  output  1  block accepts a word this cycle.
- i_data  input  N  upstream data word.
- o_valid  output  1  o_data holds a valid word.
- o_ready  input  1  downstream accepts o_data this cycle.
- o_data  output  N  oldest held word.
- count  output  2  words held (0..2).

Behaviour:
- Handshake rules:
  - Input fire: in_fire = i_valid & i_ready.
  - Output fire: out_fire = o_valid & o_ready.
  - Both are evaluated at posedge clk.
- State machine (2-bit state register):
  - EMPTY: count=0.
  - BUSY: count=1; the word is in main.
  - FULL: count=2; the older word is in main, the newer word is in skid.
- Outputs are decoded from state only:
  - i_ready = (state != FULL).
  - o_valid = (state != EMPTY).
  - o_data = main.
  - No combinational input-to-output path exists.
- Transitions (apply when flush=0):
  - EMPTY, in_fire: main<=i_data; go to BUSY.
  - EMPTY, no in_fire: stay in EMPTY.
  - BUSY, in_fire and out_fire: main<=i_data; stay in BUSY (pass-through at full rate).
  - BUSY, in_fire only: skid<=i_data; go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, out_fire: main<=skid; go to BUSY. in_fire is impossible because i_ready=0.
  - FULL, no out_fire: hold. o_data must remain stable while o_valid=1 and o_ready=0.
- Latency: a word accepted at edge k appears on o_data/o_valid after edge k (1 cycle) when the block was EMPTY.
- Ordering: strict FIFO. Words are never dropped or duplicated.
- Flush:
  - At the edge with flush=1, state goes to EMPTY regardless of in_fire/out_fire.
  - Any handshake completing in that cycle is discarded.
  - main/skid contents are don't-care afterwards.
- Reset:
  - On rst=0, state=EMPTY immediately (asynchronously), even mid-cycle or mid-transfer. Therefore o_valid=0, i_ready=1, count=0.
  - main and skid reset to 0, so o_data=0 during and after reset until the first load.
- Priority: rst > flush > handshake transitions.
- i_valid while i_ready=0 is legal and ignored. Upstream holds its data; the block does not sample it.
- X on i_data is tolerated when i_valid=0 and must not propagate into state.

Test Plan:
- Reset: drive rst=0 mid-operation while FULL holding 0x11, 0x22 -> immediately o_valid=0, i_ready=1, count=0, o_data=0x00. After release with no inputs, the block stays EMPTY.
- Single word: i_valid=1, i_data=0xA5 for one cycle with o_ready=0 -> next cycle o_valid=1, o_data=0xA5, count=1, i_ready=1. Then o_ready=1 for one cycle -> o_valid=0, count=0.
- Backpressure fill: o_ready=0; push 0x01, 0x02, 0x03 on consecutive cycles -> 0x01 and 0x02 accepted, count=2, i_ready=0, 0x03 not accepted. Upstream holds 0x03. Raise o_ready -> output sequence 0x01, 0x02, 0x03 with no loss or duplication.
- Streaming: o_ready=1 constant; push 0x00..0x0F on consecutive cycles -> one word out per cycle in order, count stays 1, i_ready never drops.
- Random stall: random i_valid/o_ready for 10k cycles with an incrementing data pattern -> scoreboard matches exactly. Assertions hold throughout:
  - o_data is stable while o_valid & !o_ready.
  - i_ready == (count != 2).
- Flush: FULL with 0x55, 0x66; flush=1 together with i_valid=1, o_ready=1 for one cycle -> next cycle count=0, o_valid=0, i_ready=1. No 0x55 handshake is counted by the scoreboard, and the word presented during flush is dropped.
